// File: rtl/apb_wait_slave.sv
// APB completer backed by a small word-addressed register memory.
// Every transfer is stretched by a fixed number of wait states before it completes.
module apb_wait_slave #(
  parameter int          DEPTH       = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 2
) (
  input  logic        Pclk,
  input  logic        Preset,
  input  logic        Psel,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pdata,
  output logic [31:0] Prdata,
  output logic        Pready,
  output logic        Pslverr,
  output logic [15:0] access_cnt
);
  localparam int          AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(DEPTH * 4);
  localparam logic [3:0]  WS   = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t        r_state, w_state_next;
  logic [3:0]    r_cnt, w_cnt_next;
  logic          r_write, r_err, r_pready, r_pslverr;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_wdata, r_prdata;
  logic [15:0]   r_access_cnt;
  logic [31:0]   r_mem [DEPTH];

  logic [31:0]   w_offset;
  logic          w_err, w_setup, w_commit, w_enter_done;
  logic          w_ld_err, w_ld_write;
  logic [AW-1:0] w_idx, w_ld_idx;

  always_comb begin
    w_offset = Paddr - BASE_ADDR;
    w_err    = (w_offset >= SPAN) || (Paddr[1:0] != 2'b00);
    w_idx    = w_offset[AW+1:2];
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_setup      = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Psel && !Penable) begin
          w_setup      = 1'b1;
          w_cnt_next   = WS;
          w_state_next = (WS == 4'd0) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!(Psel && Penable)) begin
          w_state_next = S_IDLE;
          w_cnt_next   = 4'd0;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
          if (r_cnt <= 4'd1) w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
        w_commit     = Psel && Penable;
      end
      default: w_state_next = S_IDLE;
    endcase
    // With zero wait states DONE is entered straight from IDLE, before the setup latches hold the transfer.
    w_enter_done = (w_state_next == S_DONE);
    w_ld_err     = (r_state == S_IDLE) ? w_err  : r_err;
    w_ld_write   = (r_state == S_IDLE) ? Pwrite : r_write;
    w_ld_idx     = (r_state == S_IDLE) ? w_idx  : r_idx;
  end

  always_ff @(posedge Pclk or posedge Preset) begin
    if (Preset) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_write      <= 1'b0;
      r_err        <= 1'b0;
      r_idx        <= '0;
      r_wdata      <= 32'd0;
      r_prdata     <= 32'd0;
      r_pready     <= 1'b0;
      r_pslverr    <= 1'b0;
      r_access_cnt <= 16'd0;
      for (int i = 0; i < DEPTH; i++) r_mem[AW'(i)] <= 32'd0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_pready  <= w_enter_done;
      r_pslverr <= w_enter_done && w_ld_err;
      if (w_setup) begin
        r_write <= Pwrite;
        r_err   <= w_err;
        r_idx   <= w_idx;
        r_wdata <= Pdata;
      end
      if (w_enter_done) begin
        if (w_ld_err)        r_prdata <= 32'd0;
        else if (!w_ld_write) r_prdata <= r_mem[w_ld_idx];
      end
      if (w_commit && !r_err) begin
        if (r_write) r_mem[r_idx] <= r_wdata;
        if (r_access_cnt != 16'hFFFF) r_access_cnt <= r_access_cnt + 16'd1;
      end
    end
  end

  assign Prdata     = r_prdata;
  assign Pready     = r_pready;
  assign Pslverr    = r_pslverr;
  assign access_cnt = r_access_cnt;

endmodule

// File: tb/tb_apb_wait_slave.sv
// Scoreboard bench for apb_wait_slave: one instance with two wait states, one with none.
// Stimulus pushes expected completions; per-instance monitors pop and compare on Pready.
module tb_apb_wait_slave;
  typedef struct {
    int          exp_cycle;
    bit          err;
    bit          chk_rd;
    logic [31:0] rdata;
    logic [15:0] cnt;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic [1:0]  sel, en, wr;
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic [1:0]  rdy, serr;
  logic [15:0] cnt  [2];
  logic [15:0] mcnt [2];
  exp_t        q_a[$];
  exp_t        q_b[$];
  int          cyc    = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb_wait_slave #(.DEPTH(16), .BASE_ADDR(32'h0), .WAIT_STATES(2)) u_a (
    .Pclk(clk), .Preset(rst_a), .Psel(sel[0]), .Penable(en[0]), .Pwrite(wr[0]),
    .Paddr(addr[0]), .Pdata(wdata[0]), .Prdata(rdata[0]), .Pready(rdy[0]),
    .Pslverr(serr[0]), .access_cnt(cnt[0])
  );

  apb_wait_slave #(.DEPTH(16), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_b (
    .Pclk(clk), .Preset(rst_b), .Psel(sel[1]), .Penable(en[1]), .Pwrite(wr[1]),
    .Paddr(addr[1]), .Pdata(wdata[1]), .Prdata(rdata[1]), .Pready(rdy[1]),
    .Pslverr(serr[1]), .access_cnt(cnt[1])
  );

  function automatic void check(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endfunction

  task automatic monitor(input int d);
    exp_t e;
    bit   have;
    have = 1'b0;
    if (rdy[d] === 1'b1) begin
      if (d == 0 && q_a.size() > 0) begin e = q_a.pop_front(); have = 1'b1; end
      if (d == 1 && q_b.size() > 0) begin e = q_b.pop_front(); have = 1'b1; end
      check($sformatf("dut%0d_pready_expected", d), 32'(have), 32'd1);
      if (have) begin
        check({e.name, "_latency"}, 32'(cyc), 32'(e.exp_cycle));
        check({e.name, "_pslverr"}, 32'(serr[d]), 32'(e.err));
        check({e.name, "_cnt"}, 32'(cnt[d]), 32'(e.cnt));
        if (e.chk_rd) check({e.name, "_prdata"}, rdata[d], e.rdata);
        $display("dut%0d %s done cycle=%0d prdata=%h pslverr=%0d cnt=%h",
                 d, e.name, cyc, rdata[d], serr[d], cnt[d]);
      end
    end else begin
      check($sformatf("dut%0d_pslverr_without_pready", d), 32'(serr[d]), 32'd0);
    end
  endtask

  always @(negedge clk) monitor(0);
  always @(negedge clk) monitor(1);

  // Called just after a rising edge; returns just after the completing edge.
  task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                      input bit exp_err, input logic [31:0] exp_rd, input string nm);
    exp_t e;
    bit   seen;
    sel[d] = 1'b1; en[d] = 1'b0; wr[d] = w; addr[d] = a; wdata[d] = wd;
    e.exp_cycle = cyc + ((d == 0) ? 2 : 0) + 1;
    e.err       = exp_err;
    e.chk_rd    = exp_err || !w;
    e.rdata     = exp_rd;
    e.cnt       = mcnt[d];
    e.name      = nm;
    if (!exp_err && mcnt[d] != 16'hFFFF) mcnt[d] = mcnt[d] + 16'd1;
    if (d == 0) q_a.push_back(e); else q_b.push_back(e);
    @(posedge clk); #1;
    en[d] = 1'b1;
    addr[d] = ~a; wdata[d] = ~wd;   // must be ignored after setup
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (rdy[d] === 1'b1) seen = 1'b1;
    end
    check({nm, "_completed"}, 32'(seen), 32'd1);
    @(posedge clk); #1;
    sel[d] = 1'b0; en[d] = 1'b0;
  endtask

  task automatic do_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0; rst_b = 1'b0;
    mcnt[0] = 16'd0; mcnt[1] = 16'd0;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    sel = 2'b00; en = 2'b00; wr = 2'b00;
    addr[0] = 32'd0; addr[1] = 32'd0; wdata[0] = 32'd0; wdata[1] = 32'd0;
    mcnt[0] = 16'd0; mcnt[1] = 16'd0;

    // Reset and idle state
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0; rst_b = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_pready_%0d", d), 32'(rdy[d]), 32'd0);
      check($sformatf("rst_pslverr_%0d", d), 32'(serr[d]), 32'd0);
      check($sformatf("rst_prdata_%0d", d), rdata[d], 32'd0);
      check($sformatf("rst_cnt_%0d", d), 32'(cnt[d]), 32'd0);
    end
    for (int i = 0; i < 16; i++)
      xfer(0, 1'b0, 32'(i * 4), 32'd0, 1'b0, 32'd0, $sformatf("t1_rd_w%0d", i));
    do_reset();

    // Write then read with two wait states
    xfer(0, 1'b1, 32'h8, 32'hDEADBEEF, 1'b0, 32'd0, "t2_wr");
    xfer(0, 1'b0, 32'h8, 32'd0, 1'b0, 32'hDEADBEEF, "t2_rd");
    check("t2_cnt", 32'(cnt[0]), 32'd2);

    // Zero wait states, back-to-back
    xfer(1, 1'b1, 32'h0, 32'h1111_1111, 1'b0, 32'd0, "t3_wr0");
    xfer(1, 1'b1, 32'h4, 32'h2222_2222, 1'b0, 32'd0, "t3_wr1");
    check("t3_cnt", 32'(cnt[1]), 32'd2);
    xfer(1, 1'b0, 32'h0, 32'd0, 1'b0, 32'h1111_1111, "t3_rd0");
    xfer(1, 1'b0, 32'h4, 32'd0, 1'b0, 32'h2222_2222, "t3_rd1");

    // Error decode
    xfer(0, 1'b1, 32'h40, 32'hBAD0_BAD0, 1'b1, 32'd0, "t4_wr_oor");
    xfer(0, 1'b0, 32'h8, 32'd0, 1'b0, 32'hDEADBEEF, "t4_rd_w2");
    xfer(0, 1'b0, 32'h6, 32'd0, 1'b1, 32'd0, "t4_rd_misal");
    check("t4_cnt", 32'(cnt[0]), 32'd3);
    xfer(0, 1'b0, 32'h0, 32'd0, 1'b0, 32'd0, "t4_rd_w0");

    // Abort after first wait cycle
    sel[0] = 1'b1; en[0] = 1'b0; wr[0] = 1'b1; addr[0] = 32'hC; wdata[0] = 32'h1234;
    @(posedge clk); #1;
    en[0] = 1'b1;
    @(posedge clk); #1;
    sel[0] = 1'b0; en[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_abort_pready", 32'(rdy[0]), 32'd0);
    end
    @(posedge clk); #1;
    check("t5_abort_cnt", 32'(cnt[0]), 32'd4);
    xfer(0, 1'b0, 32'hC, 32'd0, 1'b0, 32'd0, "t5_rd_w3");
    xfer(0, 1'b0, 32'h8, 32'd0, 1'b0, 32'hDEADBEEF, "t5_rd_w2");

    // Reset during WAIT
    sel[0] = 1'b1; en[0] = 1'b0; wr[0] = 1'b1; addr[0] = 32'hC; wdata[0] = 32'h1234;
    @(posedge clk); #1;
    en[0] = 1'b1;
    #3;
    rst_a = 1'b1;
    #1;
    check("t5_rst_prdata", rdata[0], 32'd0);
    check("t5_rst_cnt", 32'(cnt[0]), 32'd0);
    check("t5_rst_pready", 32'(rdy[0]), 32'd0);
    check("t5_rst_pslverr", 32'(serr[0]), 32'd0);
    @(posedge clk); #1;
    sel[0] = 1'b0; en[0] = 1'b0;
    @(posedge clk); #1;
    rst_a = 1'b0;
    mcnt[0] = 16'd0;
    @(posedge clk); #1;
    xfer(0, 1'b0, 32'hC, 32'd0, 1'b0, 32'd0, "t5_rd_w3_after_rst");
    xfer(0, 1'b0, 32'h8, 32'd0, 1'b0, 32'd0, "t5_rd_w2_after_rst");

    // Saturation: counter preloaded near the top to keep the run short
    force u_b.r_access_cnt = 16'hFFFB;
    @(posedge clk); #1;
    release u_b.r_access_cnt;
    mcnt[1] = 16'hFFFB;
    for (int i = 0; i < 6; i++)
      xfer(1, 1'b0, 32'h0, 32'd0, 1'b0, 32'h1111_1111, $sformatf("t6_rd%0d", i));
    check("t6_cnt_sat", 32'(cnt[1]), 32'h0000_FFFF);

    repeat (5) @(posedge clk);
    #1;
    check("sb_a_drained", 32'(q_a.size()), 32'd0);
    check("sb_b_drained", 32'(q_b.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_wait_slave.md
Name: apb_wait_slave

Overview:
- APB responder (completer) for the far side of the AHB-to-APB bridge.
- Accepts Psel/Penable/Pwrite/Paddr/Pdata transfers from the bridge and returns Pready/Prdata/Pslverr.
- Backed by a small word-addressed register memory, with a programmable number of wait states inserted per transfer.
- Serves as the bridge's bench-level APB target and as the basis for simple on-chip peripherals.

Parameters:
- DEPTH, 16: number of 32-bit words in the memory; power of two, 2 to 256.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be DEPTH*4 aligned.
- WAIT_STATES, 2: Pready-low cycles inserted in each access phase; range 0 to 15.

Ports:
- Pclk  input  1  clock; all logic on the rising edge.
- Preset  input  1  asynchronous, active-high reset.
- Psel  input  1  slave select.
- Penable  input  1  access-phase strobe.
- Pwrite  input  1  1 = write, 0 = read.
- Paddr  input  32  byte address.
- Pdata  input  32  write data.
- Prdata  output  32  read data.
- Pready  output  1  transfer-complete strobe.
- Pslverr  output  1  error response, qualified by Pready.
- access_cnt  output  16  count of completed non-error transfers; saturates at 16'hFFFF.

Behaviour:
- Reset: asynchronous and active-high, per the decision above.
  - Forces state=IDLE and wait counter=0.
  - Outputs: Pready=0, Pslverr=0, Prdata=0, access_cnt=0.
  - Clears all memory words to 0.
  - Applies mid-transfer too: an in-flight write is never committed.
- States: IDLE, WAIT, DONE.
- IDLE:
  - Pready=0.
  - On Psel=1 & Penable=0 (setup phase): latch Paddr/Pwrite/Pdata and load counter=WAIT_STATES.
  - Go to DONE if WAIT_STATES=0, else WAIT.
- WAIT:
  - Requires Psel=1 & Penable=1 each cycle; decrement the counter.
  - On the edge where the counter reaches 0, go to DONE.
  - If Psel or Penable drops, abort: go to IDLE with no write and no count.
- DONE (the completion cycle):
  - Pready=1. It is a register output, so it is high exactly during this cycle.
  - Prdata and Pslverr are valid in the same cycle.
  - If Psel & Penable are high at the end of the cycle, the transfer commits at that edge.
  - Next state is IDLE, with Pready=0 the following cycle.
- Timing:
  - Setup at cycle T0 puts Pready high in cycle T0+WAIT_STATES+1.
  - The access phase therefore lasts WAIT_STATES+1 cycles.
- Address decode:
  - offset = Paddr - BASE_ADDR, unsigned 32-bit.
  - Error if offset >= DEPTH*4 or Paddr[1:0] != 0.
  - Otherwise the word index is offset[log2(DEPTH)+1:2].
- Error transfer: Pslverr=1 in the DONE cycle, memory unchanged, Prdata=0, access_cnt unchanged.
- Write: memory[idx] <= latched Pdata at the completing edge.
- Read:
  - Prdata is loaded with memory[idx] on the edge entering DONE.
  - Prdata holds its value until the next completing transfer loads it again; it is not cleared between transfers.
- Read-after-write: a write completing at edge N is visible to a read whose DONE cycle follows edge N.
- Back-to-back transfers: a setup may arrive on the cycle immediately after DONE (Psel held high, Penable low). IDLE accepts it with no bubble.
- Penable=1 seen in IDLE without a prior setup: protocol error, ignored; Pready stays 0.
- Pslverr=0 whenever Pready=0.
- access_cnt:
  - +1 per completed non-error read or write.
  - Holds at 16'hFFFF.
- Address and data are sampled only at setup; changes during WAIT are ignored.

Test Plan:
1. Reset/idle:
   - Stimulus: hold Preset=1 for 3 cycles, then release with Psel=0.
   - Required: Pready=0, Pslverr=0, Prdata=0, access_cnt=0; read of each word returns 32'h0.
2. Write then read, WAIT_STATES=2:
   - Stimulus: write 32'hDEADBEEF to Paddr 32'h8, then read Paddr 32'h8.
   - Required: Pready rises exactly 3 cycles after each setup; read Prdata=32'hDEADBEEF; access_cnt=2.
3. Zero-wait, WAIT_STATES=0:
   - Stimulus: back-to-back writes to 32'h0 and 32'h4 with no idle cycle between them.
   - Required: Pready high in the first Penable cycle of each transfer; both words stored; access_cnt=2.
4. Error decode:
   - Stimulus: write to Paddr 32'h40 (DEPTH=16), then read Paddr 32'h6.
   - Required: Pslverr=1 with Pready in both transfers; no memory word changes; read Prdata=0; access_cnt unchanged.
5. Abort and reset mid-transfer:
   - Stimulus: drop Penable after the first wait cycle of a write of 32'h1234 to 32'hC.
   - Required: FSM returns to IDLE, Pready stays 0, word 3 unchanged.
   - Stimulus: repeat the write and assert Preset during WAIT.
   - Required: all outputs reset and word 3 = 0.
6. Saturation:
   - Stimulus: run 65540 completed reads.
   - Required: access_cnt stops at 16'hFFFF.
